// File: rtl/id_ex_register.sv
// ID/EX pipeline register with flush/stall handling and a syscall wait FSM.
// Optional `define ID_EX_PERF_COUNTERS_EN adds bubble_count / stall_count outputs.
module id_ex_register (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_reg_write,
    input  logic        id_mem_to_reg,
    input  logic        id_mem_write,
    input  logic        id_alu_src,
    input  logic        id_reg_dest,
    input  logic        id_syscall,
    input  logic [3:0]  id_alu_op,
    input  logic [2:0]  id_branch_variant,
    input  logic [31:0] id_rs_value,
    input  logic [31:0] id_rt_value,
    input  logic [31:0] id_imm_ext,
    input  logic [31:0] id_pc_plus_4,
    input  logic [4:0]  id_shamt,
    input  logic [4:0]  id_rs_id,
    input  logic [4:0]  id_rt_id,
    input  logic [4:0]  id_rd_id,
    input  logic        syscall_done,
    output logic        ex_reg_write,
    output logic        ex_mem_to_reg,
    output logic        ex_mem_write,
    output logic        ex_alu_src,
    output logic        ex_reg_dest,
    output logic        ex_syscall,
    output logic [3:0]  ex_alu_op,
    output logic [2:0]  ex_branch_variant,
    output logic [31:0] ex_rs_value,
    output logic [31:0] ex_rt_value,
    output logic [31:0] ex_imm_ext,
    output logic [31:0] ex_pc_plus_4,
    output logic [4:0]  ex_shamt,
    output logic [4:0]  ex_rs_id,
    output logic [4:0]  ex_rt_id,
    output logic [4:0]  ex_rd_id,
    output logic        hold_upstream,
    output logic        syscall_pending
`ifdef ID_EX_PERF_COUNTERS_EN
    ,
    output logic [31:0] bubble_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [2:0] BV_NONE = 3'd0;

    typedef enum logic {RUN, SYS_WAIT} state_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dest;
        logic        syscall;
        logic [3:0]  alu_op;
        logic [2:0]  branch_variant;
        logic [31:0] rs_value;
        logic [31:0] rt_value;
        logic [31:0] imm_ext;
        logic [31:0] pc_plus_4;
        logic [4:0]  shamt;
        logic [4:0]  rs_id;
        logic [4:0]  rt_id;
        logic [4:0]  rd_id;
    } ex_bundle_t;

    localparam ex_bundle_t BUBBLE = ex_bundle_t'({6'b0, 4'b0, BV_NONE, 148'b0});

    state_t     state, state_nxt;
    ex_bundle_t ex_q, ex_nxt, id_bundle;
    logic       load_bubble, hold_cycle;

    assign id_bundle = '{id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src,
                         id_reg_dest, id_syscall, id_alu_op, id_branch_variant,
                         id_rs_value, id_rt_value, id_imm_ext, id_pc_plus_4,
                         id_shamt, id_rs_id, id_rt_id, id_rd_id};

    // syscall_done releases SYS_WAIT and lets RUN rules act on the same edge
    always_comb begin
        state_nxt   = state;
        ex_nxt      = ex_q;
        load_bubble = 1'b0;
        hold_cycle  = 1'b0;
        if (state == SYS_WAIT && !syscall_done) begin
            hold_cycle = 1'b1;
        end else if (flush) begin
            ex_nxt      = BUBBLE;
            state_nxt   = RUN;
            load_bubble = 1'b1;
        end else if (stall) begin
            state_nxt  = RUN;
            hold_cycle = 1'b1;
        end else begin
            ex_nxt    = id_bundle;
            state_nxt = id_syscall ? SYS_WAIT : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            ex_q  <= BUBBLE;
        end else begin
            state <= state_nxt;
            ex_q  <= ex_nxt;
        end
    end

    assign hold_upstream   = (state == SYS_WAIT) && !syscall_done;
    assign syscall_pending = (state == SYS_WAIT);

    assign ex_reg_write      = ex_q.reg_write;
    assign ex_mem_to_reg     = ex_q.mem_to_reg;
    assign ex_mem_write      = ex_q.mem_write;
    assign ex_alu_src        = ex_q.alu_src;
    assign ex_reg_dest       = ex_q.reg_dest;
    assign ex_syscall        = ex_q.syscall;
    assign ex_alu_op         = ex_q.alu_op;
    assign ex_branch_variant = ex_q.branch_variant;
    assign ex_rs_value       = ex_q.rs_value;
    assign ex_rt_value       = ex_q.rt_value;
    assign ex_imm_ext        = ex_q.imm_ext;
    assign ex_pc_plus_4      = ex_q.pc_plus_4;
    assign ex_shamt          = ex_q.shamt;
    assign ex_rs_id          = ex_q.rs_id;
    assign ex_rt_id          = ex_q.rt_id;
    assign ex_rd_id          = ex_q.rd_id;

`ifdef ID_EX_PERF_COUNTERS_EN
    // free-running wrap at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count <= '0;
            stall_count  <= '0;
        end else begin
            if (load_bubble) bubble_count <= bubble_count + 32'd1;
            if (hold_cycle)  stall_count  <= stall_count + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = load_bubble ^ hold_cycle;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Table-driven bench for id_ex_register: each row is one clock with hand-picked
// inputs and the expected register/FSM state after the edge.
module tb_id_ex_register;

    localparam logic [2:0] BV_NONE = 3'd0;

    typedef struct packed {
        logic        reg_write, mem_to_reg, mem_write, alu_src, reg_dest, syscall;
        logic [3:0]  alu_op;
        logic [2:0]  branch_variant;
        logic [31:0] rs_value, rt_value, imm_ext, pc_plus_4;
        logic [4:0]  shamt, rs_id, rt_id, rd_id;
    } ex_t;

    typedef struct {
        logic       rst, stl, fls, done, sys;
        logic [7:0] seed;
        logic       chk_hold, exp_hold;
        logic       exp_bub;
        logic [7:0] exp_seed;
        logic       exp_sys, exp_pend;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, stall, flush, syscall_done;
    ex_t  id_in, act;
    logic hold_upstream, syscall_pending;
`ifdef ID_EX_PERF_COUNTERS_EN
    logic [31:0] bubble_count, stall_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_register dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_reg_write(id_in.reg_write), .id_mem_to_reg(id_in.mem_to_reg),
        .id_mem_write(id_in.mem_write), .id_alu_src(id_in.alu_src),
        .id_reg_dest(id_in.reg_dest), .id_syscall(id_in.syscall),
        .id_alu_op(id_in.alu_op), .id_branch_variant(id_in.branch_variant),
        .id_rs_value(id_in.rs_value), .id_rt_value(id_in.rt_value),
        .id_imm_ext(id_in.imm_ext), .id_pc_plus_4(id_in.pc_plus_4),
        .id_shamt(id_in.shamt), .id_rs_id(id_in.rs_id),
        .id_rt_id(id_in.rt_id), .id_rd_id(id_in.rd_id),
        .syscall_done(syscall_done),
        .ex_reg_write(act.reg_write), .ex_mem_to_reg(act.mem_to_reg),
        .ex_mem_write(act.mem_write), .ex_alu_src(act.alu_src),
        .ex_reg_dest(act.reg_dest), .ex_syscall(act.syscall),
        .ex_alu_op(act.alu_op), .ex_branch_variant(act.branch_variant),
        .ex_rs_value(act.rs_value), .ex_rt_value(act.rt_value),
        .ex_imm_ext(act.imm_ext), .ex_pc_plus_4(act.pc_plus_4),
        .ex_shamt(act.shamt), .ex_rs_id(act.rs_id),
        .ex_rt_id(act.rt_id), .ex_rd_id(act.rd_id),
        .hold_upstream(hold_upstream), .syscall_pending(syscall_pending)
`ifdef ID_EX_PERF_COUNTERS_EN
        , .bubble_count(bubble_count), .stall_count(stall_count)
`endif
    );

    // Distinct, recognisable decode bundle per seed; seed 8'h03 gives alu_op=3, rs=DEADBEEF.
    function automatic ex_t payload(input logic [7:0] s, input logic sys);
        ex_t p;
        p.reg_write      = s[0];
        p.mem_to_reg     = s[1];
        p.mem_write      = s[2];
        p.alu_src        = s[3];
        p.reg_dest       = s[4];
        p.syscall        = sys;
        p.alu_op         = s[3:0];
        p.branch_variant = s[6:4];
        p.rs_value       = 32'hDEADBEEF ^ {24'h0, s ^ 8'h03};
        p.rt_value       = {s, s, s, s};
        p.imm_ext        = {s, s, ~s, s};
        p.pc_plus_4      = 32'h0040_0000 | {24'h0, s};
        p.shamt          = s[4:0];
        p.rs_id          = s[5:1];
        p.rt_id          = ~s[4:0];
        p.rd_id          = s[7:3];
        return p;
    endfunction

    function automatic vec_t mk(input logic rst, stl, fls, done, sys, input logic [7:0] seed,
                                input logic chk_hold, exp_hold, exp_bub,
                                input logic [7:0] exp_seed, input logic exp_sys, exp_pend);
        vec_t v;
        v = '{rst, stl, fls, done, sys, seed, chk_hold, exp_hold, exp_bub, exp_seed, exp_sys, exp_pend};
        return v;
    endfunction

    task automatic chk1(input string name, input logic a, input logic e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, a, e);
        end
    endtask

    task automatic chk_bundle(input string name, input ex_t e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, e);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    vec_t tbl[27];
    ex_t  bubble, exp_b;

    initial begin
        bubble = '0;
        bubble.branch_variant = BV_NONE;
        //            rst st fl dn sy seed  ch eh bub eseed esys epend
        tbl[0]  = mk(1, 0, 0, 0, 0, 8'h5A, 0, 0, 1, 8'h00, 0, 0); // reset
        tbl[1]  = mk(0, 0, 0, 0, 0, 8'h03, 1, 0, 0, 8'h03, 0, 0); // first load
        tbl[2]  = mk(0, 1, 0, 0, 0, 8'h11, 1, 0, 0, 8'h03, 0, 0); // stall x3
        tbl[3]  = mk(0, 1, 0, 0, 0, 8'h22, 1, 0, 0, 8'h03, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 8'h33, 1, 0, 0, 8'h03, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 8'h44, 1, 0, 0, 8'h44, 0, 0); // release
        tbl[6]  = mk(0, 1, 1, 0, 0, 8'h55, 1, 0, 1, 8'h00, 0, 0); // flush beats stall
        tbl[7]  = mk(0, 0, 0, 0, 0, 8'h66, 1, 0, 0, 8'h66, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 8'h77, 1, 0, 0, 8'h77, 0, 0); // done ignored in RUN
        tbl[9]  = mk(0, 0, 0, 0, 1, 8'h81, 1, 0, 0, 8'h81, 1, 1); // syscall captured
        tbl[10] = mk(0, 0, 1, 0, 0, 8'h90, 1, 1, 0, 8'h81, 1, 1); // wait: flush ignored
        tbl[11] = mk(0, 1, 0, 0, 0, 8'h91, 1, 1, 0, 8'h81, 1, 1); // wait: stall ignored
        tbl[12] = mk(0, 0, 0, 0, 0, 8'h92, 1, 1, 0, 8'h81, 1, 1);
        tbl[13] = mk(0, 0, 0, 0, 1, 8'h93, 1, 1, 0, 8'h81, 1, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 8'h94, 1, 1, 0, 8'h81, 1, 1);
        tbl[15] = mk(0, 0, 0, 1, 0, 8'hA2, 1, 0, 0, 8'hA2, 0, 0); // done: load same edge
        tbl[16] = mk(0, 0, 0, 0, 1, 8'hB3, 1, 0, 0, 8'hB3, 1, 1);
        tbl[17] = mk(0, 0, 0, 1, 1, 8'hC4, 1, 0, 0, 8'hC4, 1, 1); // back-to-back syscall
        tbl[18] = mk(0, 0, 0, 0, 0, 8'hD5, 1, 1, 0, 8'hC4, 1, 1);
        tbl[19] = mk(0, 0, 1, 1, 0, 8'hD6, 1, 0, 1, 8'h00, 0, 0); // done + flush
        tbl[20] = mk(0, 0, 0, 0, 1, 8'hE6, 1, 0, 0, 8'hE6, 1, 1);
        tbl[21] = mk(1, 0, 0, 0, 0, 8'hE7, 1, 1, 1, 8'h00, 0, 0); // reset mid-wait
        tbl[22] = mk(0, 1, 0, 0, 0, 8'h07, 1, 0, 1, 8'h00, 0, 0); // hold after reset is 0
        tbl[23] = mk(0, 0, 0, 0, 1, 8'h0F, 1, 0, 0, 8'h0F, 1, 1);
        tbl[24] = mk(0, 1, 0, 1, 0, 8'h1E, 1, 0, 0, 8'h0F, 1, 0); // done + stall: hold, RUN
        tbl[25] = mk(0, 0, 0, 1, 0, 8'h2D, 1, 0, 0, 8'h2D, 0, 0);
        tbl[26] = mk(0, 0, 0, 0, 0, 8'hFF, 1, 0, 0, 8'hFF, 0, 0);

        for (int i = 0; i < 27; i++) begin
            reset        = tbl[i].rst;
            stall        = tbl[i].stl;
            flush        = tbl[i].fls;
            syscall_done = tbl[i].done;
            id_in        = payload(tbl[i].seed, tbl[i].sys);
            #1;
            if (tbl[i].chk_hold) chk1($sformatf("hold_upstream[%0d]", i), hold_upstream, tbl[i].exp_hold);
            @(posedge clk);
            #1;
            exp_b = tbl[i].exp_bub ? bubble : payload(tbl[i].exp_seed, tbl[i].exp_sys);
            chk_bundle($sformatf("ex_bundle[%0d]", i), exp_b);
            chk1($sformatf("syscall_pending[%0d]", i), syscall_pending, tbl[i].exp_pend);
            if (i == 1) begin
                chk32("ex_alu_op_3", {28'h0, act.alu_op}, 32'h3);
                chk32("ex_rs_deadbeef", act.rs_value, 32'hDEADBEEF);
            end
        end

`ifdef ID_EX_PERF_COUNTERS_EN
        // Counters: 2 flushes and 3 stall cycles after reset.
        stall = 0; flush = 0; syscall_done = 0; id_in = payload(8'h12, 1'b0);
        reset = 1; @(posedge clk); #1;
        reset = 0;
        chk32("bubble_count_reset", bubble_count, 32'd0);
        chk32("stall_count_reset", stall_count, 32'd0);
        flush = 1; repeat (2) @(posedge clk); #1;
        flush = 0; stall = 1; repeat (3) @(posedge clk); #1;
        stall = 0; @(posedge clk); #1;
        chk32("bubble_count_2", bubble_count, 32'd2);
        chk32("stall_count_3", stall_count, 32'd3);
        force dut.bubble_count = 32'hFFFF_FFFF;
        force dut.stall_count  = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_count;
        release dut.stall_count;
        flush = 1; @(posedge clk); #1;
        flush = 0;
        chk32("bubble_count_wrap", bubble_count, 32'd0);
        stall = 1; @(posedge clk); #1;
        stall = 0;
        chk32("stall_count_wrap", stall_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
